// File: rtl/slurm16_uart_pkg.sv
// slurm16_uart_pkg
// Shared definitions for the slurm16 UART receive and transmit paths.
//   - 3-bit state encoding for the receive FSM, and an enum built on it
//   - calc_div / calc_half: derive the baud divider from clock and line rate
package slurm16_uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_WAITHI = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_STOP   = ST_STOP,
    S_WAITHI = ST_WAITHI
  } rx_state_e;

  // Rounded clocks per bit; adding baud/2 before dividing rounds to nearest.
  function automatic int calc_div(input int clock_freq, input int baud);
    return (clock_freq + baud / 2) / baud;
  endfunction

  // Clocks from the detected start edge to the middle of the start bit.
  function automatic int calc_half(input int div);
    return div / 2;
  endfunction

endpackage

// File: rtl/slurm16_rx_fifo.sv
// slurm16_rx_fifo
// Generic synchronous show-ahead FIFO. The head entry is presented on head_o
// whenever the FIFO is not empty; pop_i advances it on the next clock.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   push_i, push_data_i write request and data (ignored when full unless
//                       a pop happens in the same cycle)
//   pop_i              advance head (ignored when empty)
//   head_o             current head entry, 0 while empty
//   full_o, empty_o    status
//   count_o            number of stored entries, 0..DEPTH
module slurm16_rx_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // push when it is also being popped.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally because
  // DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because head_o is gated by empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/slurm16_uart_rx.sv
// slurm16_uart_rx
// UART 8N1 receiver for slurm16. Recovers bytes LSB first from an
// asynchronous line, buffers them in a show-ahead FIFO and reports sticky
// framing / overrun errors.
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   uart_rx_i      asynchronous serial input, idles high
//   rd_en_i        pop the FIFO head (ignored while empty)
//   clr_err_i      clear frame_err_o and overrun_o
//   rd_data_o      FIFO head, valid while rx_valid_o
//   rx_valid_o     FIFO not empty
//   fifo_count_o   FIFO occupancy
//   frame_err_o    sticky: a stop bit was sampled low
//   overrun_o      sticky: a byte was dropped on a full FIFO
//   irq_o          rx_valid_o | frame_err_o | overrun_o
module slurm16_uart_rx
  import slurm16_uart_pkg::*;
#(
  parameter  int CLOCK_FREQ = 10000000,
  parameter  int BAUD       = 115200,
  parameter  int FIFO_DEPTH = 16,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          uart_rx_i,
  input  logic          rd_en_i,
  input  logic          clr_err_i,
  output logic [7:0]    rd_data_o,
  output logic          rx_valid_o,
  output logic [CW-1:0] fifo_count_o,
  output logic          frame_err_o,
  output logic          overrun_o,
  output logic          irq_o
);

  localparam int          DIV         = calc_div(CLOCK_FREQ, BAUD);
  localparam int          HALF        = calc_half(DIV);
  localparam logic [15:0] DIV_RELOAD  = 16'(DIV - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(HALF - 1);

  logic        sync1_q, sync2_q;
  logic        rx_s;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        tick;
  logic        push;
  logic        frame_err_set;
  logic        overrun_set;
  logic        pop;
  logic        fifo_full, fifo_empty;

  assign rx_s = sync2_q;
  assign tick = (cnt_q == 16'd0);

  // Two-flop synchronizer; reset to the idle (high) line level so a reset
  // never looks like a start edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
    end
  end

  // Receive FSM state, baud counter, bit index and shifter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic. The first tick lands mid start bit, every following
  // tick one bit period later, so each sample is taken near bit centre.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    push          = 1'b0;
    frame_err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_d   = HALF_RELOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rx_s) begin
            cnt_d     = DIV_RELOAD;
            bit_idx_d = 3'd0;
            state_d   = S_DATA;
          end else begin
            // Line was back high mid start bit: treat as a glitch.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = DIV_RELOAD;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_s) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_d       = S_WAITHI;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_WAITHI: begin
        // Hold off until the line recovers so a long break flags only once.
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  slurm16_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (rd_en_i),
    .head_o      (rd_data_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count_o)
  );

  // A byte is only lost when the FIFO is full and nobody pops this cycle.
  assign pop         = rd_en_i && !fifo_empty;
  assign overrun_set = push && fifo_full && !pop;

  // Sticky error flags; a set event in the same cycle as a clear wins.
  always_comb begin
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (clr_err_i) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (frame_err_set) frame_err_d = 1'b1;
    if (overrun_set)   overrun_d   = 1'b1;
  end

  // Sticky flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_valid_o  = !fifo_empty;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign irq_o       = rx_valid_o | frame_err_q | overrun_q;

endmodule

// File: tb/tb_slurm16_uart_rx.sv
// tb_slurm16_uart_rx
// Drives 8N1 frames into slurm16_uart_rx and compares its outputs against a
// byte-level model: a queue of bytes that should be buffered plus the two
// sticky flags. The model is updated when a frame or bus operation is
// complete; a compare process checks every quiet cycle against it, and
// directed literal checks pin the model at key points.
module tb_slurm16_uart_rx;

  localparam int BIT   = 8681;
  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       uart_rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic [4:0] fifo_count;
  logic       frame_err;
  logic       overrun;
  logic       irq;

  int         assertions = 0;
  int         failures   = 0;
  bit         checkEn    = 0;

  logic [7:0] modelQ[$];
  bit         mFrameErr  = 0;
  bit         mOverrun   = 0;

  slurm16_uart_rx dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .uart_rx_i    (uart_rx),
    .rd_en_i      (rd_en),
    .clr_err_i    (clr_err),
    .rd_data_o    (rd_data),
    .rx_valid_o   (rx_valid),
    .fifo_count_o (fifo_count),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun),
    .irq_o        (irq)
  );

  // 100-unit clock period.
  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Sends one frame. resetBit >= 0 pulses reset in the middle of that data
  // bit (frame abandoned); popWithStop means the caller pops the FIFO on the
  // stop-bit sample cycle.
  task automatic applyStimulus(input logic [7:0] data, input bit stopBit,
                               input int resetBit, input bit popWithStop);
    checkEn = 0;
    uart_rx = 1'b0;
    #BIT;
    for (int i = 0; i < 8; i++) begin
      uart_rx = data[i];
      if (i == resetBit) begin
        #4000;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        modelQ.delete();
        mFrameErr = 0;
        mOverrun  = 0;
        checkOutput("rst_rx_valid", 32'(rx_valid), 32'h0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'h0);
        checkOutput("rst_count", 32'(fifo_count), 32'h0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'h0);
        checkOutput("rst_overrun", 32'(overrun), 32'h0);
        checkOutput("rst_irq", 32'(irq), 32'h0);
        #4000;
      end else begin
        #BIT;
      end
    end
    uart_rx = stopBit;
    #BIT;
    uart_rx = 1'b1;
    if (resetBit < 0) begin
      if (popWithStop && modelQ.size() > 0) void'(modelQ.pop_front());
      if (stopBit) begin
        if (modelQ.size() < DEPTH) modelQ.push_back(data);
        else                       mOverrun = 1;
      end else begin
        mFrameErr = 1;
      end
    end
    checkEn = 1;
  endtask

  task automatic applyRead();
    @(negedge clk) rd_en = 1'b1;
    @(posedge clk);
    #1;
    if (modelQ.size() > 0) void'(modelQ.pop_front());
    @(negedge clk) rd_en = 1'b0;
  endtask

  task automatic applyClear();
    @(negedge clk) clr_err = 1'b1;
    @(posedge clk);
    #1;
    mFrameErr = 0;
    mOverrun  = 0;
    @(negedge clk) clr_err = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the model while the line is quiet.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("rx_valid", 32'(rx_valid), 32'(modelQ.size() != 0));
      checkOutput("fifo_count", 32'(fifo_count), 32'(modelQ.size()));
      if (modelQ.size() != 0) checkOutput("rd_data", 32'(rd_data), 32'(modelQ[0]));
      checkOutput("frame_err", 32'(frame_err), 32'(mFrameErr));
      checkOutput("overrun", 32'(overrun), 32'(mOverrun));
      checkOutput("irq", 32'(irq), 32'((modelQ.size() != 0) || mFrameErr || mOverrun));
    end
  end

  initial begin
    rst     = 1'b1;
    uart_rx = 1'b1;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'h0);
    checkOutput("reset_count", 32'(fifo_count), 32'h0);
    checkOutput("reset_rd_data", 32'(rd_data), 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkEn = 1;

    // Back-to-back frames with no idle time.
    applyStimulus(8'h55, 1'b1, -1, 1'b0);
    applyStimulus(8'hA3, 1'b1, -1, 1'b0);
    @(negedge clk);
    checkOutput("t1_count", 32'(fifo_count), 32'h2);
    checkOutput("t1_head0", 32'(rd_data), 32'h55);
    applyRead();
    checkOutput("t1_head1", 32'(rd_data), 32'hA3);
    applyRead();
    checkOutput("t1_empty", 32'(rx_valid), 32'h0);

    // Short low glitch must not start a frame.
    #BIT;
    uart_rx = 1'b0;
    #2000;
    uart_rx = 1'b1;
    #20000;
    @(negedge clk);
    checkOutput("t2_count", 32'(fifo_count), 32'h0);
    checkOutput("t2_frame_err", 32'(frame_err), 32'h0);
    checkOutput("t2_irq", 32'(irq), 32'h0);

    // Framing error, clear, then a clean byte.
    applyStimulus(8'hA5, 1'b0, -1, 1'b0);
    #BIT;
    @(negedge clk);
    checkOutput("t3_frame_err", 32'(frame_err), 32'h1);
    checkOutput("t3_irq", 32'(irq), 32'h1);
    checkOutput("t3_count", 32'(fifo_count), 32'h0);
    applyClear();
    checkOutput("t3_cleared", 32'(frame_err), 32'h0);
    applyStimulus(8'h3C, 1'b1, -1, 1'b0);
    @(negedge clk);
    checkOutput("t3_head", 32'(rd_data), 32'h3C);
    checkOutput("t3_count2", 32'(fifo_count), 32'h1);

    // Mid-frame reset with data and a flag pending beforehand.
    #BIT;
    applyStimulus(8'h12, 1'b0, -1, 1'b0);
    #BIT;
    applyStimulus(8'hF0, 1'b1, 4, 1'b0);
    #BIT;
    @(negedge clk);
    checkOutput("t5_lost", 32'(fifo_count), 32'h0);
    applyStimulus(8'h81, 1'b1, -1, 1'b0);
    @(negedge clk);
    checkOutput("t5_head", 32'(rd_data), 32'h81);
    checkOutput("t5_count", 32'(fifo_count), 32'h1);
    applyRead();

    // Seventeen bytes without reads: last one dropped.
    #BIT;
    for (int i = 0; i < 17; i++) applyStimulus(8'(i), 1'b1, -1, 1'b0);
    @(negedge clk);
    checkOutput("t4_count", 32'(fifo_count), 32'h10);
    checkOutput("t4_overrun", 32'(overrun), 32'h1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("t4_order", 32'(rd_data), 32'(i));
      applyRead();
    end
    checkOutput("t4_empty", 32'(rx_valid), 32'h0);
    applyClear();
    checkOutput("t4_cleared", 32'(overrun), 32'h0);

    // Refill, then pop exactly on the stop-bit sample of a 17th byte.
    // From a start edge on a falling clock: 2 synchronizer cycles, 1 IDLE
    // cycle, 43 to mid start bit, 9*87 more to mid stop bit, so the sample
    // edge is 828.5 periods later.
    #BIT;
    for (int i = 0; i < 16; i++) applyStimulus(8'h20 + 8'(i), 1'b1, -1, 1'b0);
    @(negedge clk);
    fork
      applyStimulus(8'h77, 1'b1, -1, 1'b1);
      begin
        repeat (828) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    @(negedge clk);
    checkOutput("t6_count", 32'(fifo_count), 32'h10);
    checkOutput("t6_overrun", 32'(overrun), 32'h0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("t6_order", 32'(rd_data), (i < 15) ? 32'(8'h21 + 8'(i)) : 32'h77);
      applyRead();
    end
    checkOutput("t6_empty", 32'(rx_valid), 32'h0);

    repeat (5) @(negedge clk);
    checkEn = 0;
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
